// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter for the shared register-file write port.
// Four writeback sources compete; the grant, mux select and write address are registered.
module wb_port_arbiter #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [3:0]          req_i,
  input  logic [4*ADDR_W-1:0] addr_i,
  input  logic                freeze_i,
  output logic [1:0]          sel_o,
  output logic [3:0]          ack_o,
  output logic                wr_en_o,
  output logic [ADDR_W-1:0]   wr_addr_o,
  output logic                conflict_o,
  output logic [CNT_W-1:0]    conf_cnt_o
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [1:0]        rr_ptr;
  logic [3:0]        elig_p0;
  logic [1:0]        win_p0;
  logic              hit_p0;
  logic              multi_p0;
  logic [ADDR_W-1:0] win_addr_p0;

  // Stage p0: arbitration; the requester in its ack cycle is masked out
  always_comb begin
    logic [1:0] idx;
    elig_p0  = req_i & ~ack_o;
    win_p0   = rr_ptr;
    hit_p0   = 1'b0;
    idx      = rr_ptr;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr + 2'(k);
      if (!hit_p0 && elig_p0[idx]) begin
        win_p0 = idx;
        hit_p0 = 1'b1;
      end
    end
    multi_p0    = ($countones(elig_p0) >= 2);
    win_addr_p0 = addr_i[win_p0*ADDR_W +: ADDR_W];
  end

  // Stage p1: registered grant / write cycle
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sel_o      <= '0;
      ack_o      <= '0;
      wr_en_o    <= 1'b0;
      wr_addr_o  <= '0;
      conflict_o <= 1'b0;
      conf_cnt_o <= '0;
      rr_ptr     <= '0;
    end else begin
      if (hit_p0 && !freeze_i) begin
        sel_o     <= win_p0;
        ack_o     <= 4'b0001 << win_p0;
        wr_addr_o <= win_addr_p0;
        wr_en_o   <= (win_addr_p0 != '0);
        rr_ptr    <= win_p0 + 2'd1;
      end else begin
        ack_o   <= '0;
        wr_en_o <= 1'b0;
      end
      conflict_o <= multi_p0 && !freeze_i;
      if (multi_p0 && !freeze_i)
        conf_cnt_o <= sat_inc(conf_cnt_o);
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Table-driven bench for wb_port_arbiter with an expected-result queue.
module tb_wb_port_arbiter;

  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;

  logic                Clk = 1'b0;
  logic                Reset;
  logic [3:0]          req_i;
  logic [4*ADDR_W-1:0] addr_i;
  logic                freeze_i;
  logic [1:0]          sel_o;
  logic [3:0]          ack_o;
  logic                wr_en_o;
  logic [ADDR_W-1:0]   wr_addr_o;
  logic                conflict_o;
  logic [CNT_W-1:0]    conf_cnt_o;

  wb_port_arbiter #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .req_i(req_i), .addr_i(addr_i), .freeze_i(freeze_i),
    .sel_o(sel_o), .ack_o(ack_o), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
    .conflict_o(conflict_o), .conf_cnt_o(conf_cnt_o)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       frz;
    logic       a1z;
    logic [3:0] ack;
    logic [1:0] sel;
    logic       we;
    logic [4:0] wa;
    logic       conf;
  } vec_t;

  typedef struct {
    logic [3:0]       ack;
    logic [1:0]       sel;
    logic             we;
    logic [4:0]       wa;
    logic             conf;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;
  logic [CNT_W-1:0] cnt_m = '0;

  function automatic vec_t v(logic rst, logic [3:0] req, logic frz, logic a1z,
                             logic [3:0] ack, logic [1:0] sel, logic we,
                             logic [4:0] wa, logic conf);
    vec_t r;
    r.rst = rst; r.req = req; r.frz = frz; r.a1z = a1z;
    r.ack = ack; r.sel = sel; r.we = we; r.wa = wa; r.conf = conf;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input vec_t t);
    exp_t e;
    exp_t g;
    @(negedge Clk);
    Reset    = t.rst;
    req_i    = t.req;
    freeze_i = t.frz;
    addr_i   = {5'd30, 5'd17, (t.a1z ? 5'd0 : 5'd9), 5'd5};
    if (t.rst) cnt_m = '0;
    else if (t.conf && cnt_m != '1) cnt_m = cnt_m + 1'b1;
    e.ack = t.ack; e.sel = t.sel; e.we = t.we; e.wa = t.wa; e.conf = t.conf; e.cnt = cnt_m;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    if (sb.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard: empty queue at t=%0t", $time);
    end else begin
      g = sb.pop_front();
      chk("ack",      int'(ack_o),      int'(g.ack));
      chk("sel",      int'(sel_o),      int'(g.sel));
      chk("wr_en",    int'(wr_en_o),    int'(g.we));
      chk("wr_addr",  int'(wr_addr_o),  int'(g.wa));
      chk("conflict", int'(conflict_o), int'(g.conf));
      chk("conf_cnt", int'(conf_cnt_o), int'(g.cnt));
    end
  endtask

  initial begin
    vec_t t;
    logic [1:0] w;
    Reset = 1'b1; req_i = '0; addr_i = '0; freeze_i = 1'b0;

    //            rst req     frz a1z  ack     sel  we  wa  conf
    tbl.push_back(v(1, 4'b1111, 0, 0, 4'b0000, 2'd0, 0, 0,  0));
    tbl.push_back(v(0, 4'b0100, 0, 0, 4'b0100, 2'd2, 1, 17, 0));
    tbl.push_back(v(0, 4'b0000, 0, 0, 4'b0000, 2'd2, 0, 17, 0));
    tbl.push_back(v(0, 4'b0010, 0, 1, 4'b0010, 2'd1, 0, 0,  0));
    tbl.push_back(v(0, 4'b0000, 0, 0, 4'b0000, 2'd1, 0, 0,  0));
    tbl.push_back(v(0, 4'b0001, 0, 0, 4'b0001, 2'd0, 1, 5,  0));
    tbl.push_back(v(0, 4'b1001, 1, 0, 4'b0000, 2'd0, 0, 5,  0));
    tbl.push_back(v(0, 4'b1001, 1, 0, 4'b0000, 2'd0, 0, 5,  0));
    tbl.push_back(v(0, 4'b1001, 1, 0, 4'b0000, 2'd0, 0, 5,  0));
    tbl.push_back(v(0, 4'b1001, 0, 0, 4'b1000, 2'd3, 1, 30, 1));
    tbl.push_back(v(0, 4'b1001, 0, 0, 4'b0001, 2'd0, 1, 5,  0));
    tbl.push_back(v(0, 4'b0000, 0, 0, 4'b0000, 2'd0, 0, 5,  0));
    tbl.push_back(v(0, 4'b0001, 0, 0, 4'b0001, 2'd0, 1, 5,  0));
    tbl.push_back(v(0, 4'b0001, 0, 0, 4'b0000, 2'd0, 0, 5,  0));
    tbl.push_back(v(0, 4'b0001, 0, 0, 4'b0001, 2'd0, 1, 5,  0));
    tbl.push_back(v(0, 4'b0001, 0, 0, 4'b0000, 2'd0, 0, 5,  0));
    tbl.push_back(v(0, 4'b0001, 0, 0, 4'b0001, 2'd0, 1, 5,  0));
    tbl.push_back(v(1, 4'b1111, 0, 0, 4'b0000, 2'd0, 0, 0,  0));
    tbl.push_back(v(0, 4'b1111, 0, 0, 4'b0001, 2'd0, 1, 5,  1));
    tbl.push_back(v(0, 4'b1111, 0, 0, 4'b0010, 2'd1, 1, 9,  1));
    tbl.push_back(v(0, 4'b1111, 0, 0, 4'b0100, 2'd2, 1, 17, 1));
    tbl.push_back(v(0, 4'b1111, 0, 0, 4'b1000, 2'd3, 1, 30, 1));
    tbl.push_back(v(0, 4'b1111, 0, 0, 4'b0001, 2'd0, 1, 5,  1));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Counter saturation: keep all four requesting; rotation continues from requester 1
    w = 2'd1;
    for (int i = 0; i < 14; i++) begin
      t = v(0, 4'b1111, 0, 0, 4'b0001 << w, w, 1,
            (w == 2'd0) ? 5'd5 : (w == 2'd1) ? 5'd9 : (w == 2'd2) ? 5'd17 : 5'd30, 1);
      step(t);
      w = w + 2'd1;
    end
    chk("conf_cnt_saturated", int'(conf_cnt_o), (1 << CNT_W) - 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
